// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - write-back, write-allocate set-associative byte cache with age-based LRU
// One request in flight; misses write back a dirty victim, fill the line, then re-run the lookup.
module set_assoc_cache #(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_BYTES = 4,
  parameter int NUM_SETS    = 4,
  parameter int NUM_WAYS    = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      core_req_valid,
  output logic                                      core_ready,
  input  logic                                      core_write,
  input  logic [ADDR_W-1:0]                         core_addr,
  input  logic [7:0]                                core_wdata,
  output logic                                      core_resp_valid,
  output logic [7:0]                                core_rdata,
  output logic                                      core_hit,
  output logic                                      mem_req_valid,
  input  logic                                      mem_ready,
  output logic                                      mem_write,
  output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0]     mem_addr,
  output logic [BLOCK_BYTES*8-1:0]                  mem_wdata,
  input  logic                                      mem_resp_valid,
  input  logic [BLOCK_BYTES*8-1:0]                  mem_rdata,
  output logic [31:0]                               hit_count,
  output logic [31:0]                               miss_count
);
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int LINE_W = BLOCK_BYTES * 8;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP} state_t;
  state_t r_state, w_next;

  logic              r_valid [NUM_SETS][NUM_WAYS];
  logic              r_dirty [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]  r_tags  [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0] r_data  [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]  r_age   [NUM_SETS][NUM_WAYS];

  logic              r_write;
  logic [7:0]        r_wdata;
  logic [OFF_W-1:0]  r_off;
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic              r_first;
  logic [WAY_W-1:0]  r_victim;
  logic [7:0]        r_rdata;
  logic              r_hit;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;

  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic [WAY_W-1:0]  w_vict_way;
  logic [WAY_W-1:0]  w_old_age;

  assign core_rdata = r_rdata;
  assign core_hit   = r_hit;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

  // Victim priority: lowest invalid way overrides the oldest way.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_vict_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_valid[r_idx][w] && r_tags[r_idx][w] == r_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_age[r_idx][w] == WAY_W'(NUM_WAYS - 1)) w_vict_way = WAY_W'(w);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[r_idx][w]) w_vict_way = WAY_W'(w);
    end
    w_old_age = r_age[r_idx][w_hit_way];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    core_ready      = 1'b0;
    core_resp_valid = 1'b0;
    mem_req_valid   = 1'b0;
    mem_write       = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    case (r_state)
      IDLE: begin
        core_ready = 1'b1;
        if (core_req_valid) w_next = LOOKUP;
      end
      LOOKUP: begin
        if (w_hit)                         w_next = RESP;
        else if (r_dirty[r_idx][w_vict_way]) w_next = WB_REQ;
        else                               w_next = FILL_REQ;
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_write     = 1'b1;
        mem_addr      = {r_tags[r_idx][r_victim], r_idx};
        mem_wdata     = r_data[r_idx][r_victim];
        if (mem_ready) w_next = WB_WAIT;
      end
      WB_WAIT:   if (mem_resp_valid) w_next = FILL_REQ;
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = {r_tag, r_idx};
        if (mem_ready) w_next = FILL_WAIT;
      end
      FILL_WAIT: if (mem_resp_valid) w_next = LOOKUP;
      RESP: begin
        core_resp_valid = 1'b1;
        w_next          = IDLE;
      end
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= WAY_W'(w);
        end
      end
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_off      <= '0;
      r_idx      <= '0;
      r_tag      <= '0;
      r_first    <= 1'b0;
      r_victim   <= '0;
      r_rdata    <= '0;
      r_hit      <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (core_req_valid) begin
            r_write <= core_write;
            r_wdata <= core_wdata;
            r_off   <= core_addr[OFF_W-1:0];
            r_idx   <= core_addr[OFF_W+IDX_W-1:OFF_W];
            r_tag   <= core_addr[ADDR_W-1:OFF_W+IDX_W];
            r_first <= 1'b1;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_hit   <= r_first;
            r_rdata <= r_data[r_idx][w_hit_way][{r_off, 3'b000} +: 8];
            if (r_write) begin
              r_data[r_idx][w_hit_way][{r_off, 3'b000} +: 8] <= r_wdata;
              r_dirty[r_idx][w_hit_way] <= 1'b1;
            end
            if (NUM_WAYS > 1) begin
              for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == w_hit_way)        r_age[r_idx][w] <= '0;
                else if (r_age[r_idx][w] < w_old_age) r_age[r_idx][w] <= r_age[r_idx][w] + 1'b1;
              end
            end
            if (r_first && r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 1'b1;
          end else begin
            r_victim <= w_vict_way;
            r_first  <= 1'b0;
            if (r_first && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 1'b1;
          end
        end
        WB_WAIT: if (mem_resp_valid) r_dirty[r_idx][r_victim] <= 1'b0;
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            r_data[r_idx][r_victim]  <= mem_rdata;
            r_tags[r_idx][r_victim]  <= r_tag;
            r_valid[r_idx][r_victim] <= 1'b1;
            r_dirty[r_idx][r_victim] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - vector table plus scoreboard bench for set_assoc_cache
// A behavioural memory answers line requests; expected values come from the table.
module tb_set_assoc_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid, core_ready, core_write;
  logic [15:0] core_addr;
  logic [7:0]  core_wdata, core_rdata;
  logic        core_resp_valid, core_hit;
  logic        mem_req_valid, mem_ready, mem_write;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_resp_valid;
  logic [31:0] hit_count, miss_count;

  set_assoc_cache dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_ready(core_ready), .core_write(core_write),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_resp_valid(core_resp_valid),
    .core_rdata(core_rdata), .core_hit(core_hit),
    .mem_req_valid(mem_req_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        chk_rd;
    logic [7:0]  rdata;
    logic        hit;
    int          wb;
    logic [13:0] wb_addr;
    logic [31:0] wb_data;
    int          fill;
    logic [13:0] fill_addr;
  } vec_t;

  typedef struct {
    string      nm;
    logic       chk_rd;
    logic [7:0] rdata;
    logic       hit;
  } sb_t;

  int   total = 0;
  int   bad = 0;
  sb_t  sb_q[$];
  vec_t vecs[14];

  logic [31:0] mem_model [int];
  bit          mem_stall = 0, mem_hold = 0, pend = 0, pend_wr = 0;
  logic [13:0] pend_addr;
  int          n_wb = 0, n_fill = 0;
  logic [13:0] last_wb_addr, last_fill_addr;
  logic [31:0] last_wb_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  function automatic logic [31:0] rd_line(input logic [13:0] a);
    if (mem_model.exists(int'(a))) return mem_model[int'(a)];
    return {4{a[7:0]}};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                              input logic chk_rd, input logic [7:0] rdata, input logic hit,
                              input int wb, input logic [13:0] wb_addr, input logic [31:0] wb_data,
                              input int fill, input logic [13:0] fill_addr);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.chk_rd = chk_rd; v.rdata = rdata; v.hit = hit;
    v.wb = wb; v.wb_addr = wb_addr; v.wb_data = wb_data; v.fill = fill; v.fill_addr = fill_addr;
    return v;
  endfunction

  // Memory: accepts when not stalled, answers one cycle after acceptance unless held.
  initial begin
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_resp_valid = 1'b0;
      if (rst) pend = 0;
      else if (pend) begin
        if (!mem_hold) begin
          mem_resp_valid = 1'b1;
          mem_rdata = pend_wr ? 32'h0 : rd_line(pend_addr);
          pend = 0;
        end
      end else if (mem_req_valid && !mem_stall) begin
        mem_ready = 1'b1;
        pend = 1; pend_wr = mem_write; pend_addr = mem_addr;
        if (mem_write) begin
          n_wb++; last_wb_addr = mem_addr; last_wb_data = mem_wdata;
          mem_model[int'(mem_addr)] = mem_wdata;
        end else begin
          n_fill++; last_fill_addr = mem_addr;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && core_resp_valid) begin
      if (sb_q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
      else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.chk_rd) chk({e.nm, "_rdata"}, 64'(core_rdata), 64'(e.rdata));
        chk({e.nm, "_hit"}, 64'(core_hit), 64'(e.hit));
      end
    end
  end

  task automatic run_req(input vec_t v, input string nm);
    int  t, wb0, fl0;
    sb_t e;
    t = 0;
    while (!core_ready && t < 100) begin @(negedge clk); t++; end
    if (!core_ready) chk({nm, "_ready_timeout"}, 64'd0, 64'd1);
    wb0 = n_wb; fl0 = n_fill;
    e.nm = nm; e.chk_rd = v.chk_rd; e.rdata = v.rdata; e.hit = v.hit;
    sb_q.push_back(e);
    core_req_valid = 1'b1; core_write = v.wr; core_addr = v.addr; core_wdata = v.wdata;
    @(negedge clk);
    core_req_valid = 1'b0;
    t = 1;
    while (!core_resp_valid && t < 500) begin @(negedge clk); t++; end
    if (!core_resp_valid) begin
      chk({nm, "_resp_timeout"}, 64'd0, 64'd1);
      sb_q.delete();
    end
    if (v.hit) chk({nm, "_latency"}, 64'(t), 64'd2);
    chk({nm, "_wb_n"}, 64'(n_wb - wb0), 64'(v.wb));
    if (v.wb != 0) begin
      chk({nm, "_wb_addr"}, 64'(last_wb_addr), 64'(v.wb_addr));
      chk({nm, "_wb_data"}, 64'(last_wb_data), 64'(v.wb_data));
    end
    chk({nm, "_fill_n"}, 64'(n_fill - fl0), 64'(v.fill));
    if (v.fill != 0) chk({nm, "_fill_addr"}, 64'(last_fill_addr), 64'(v.fill_addr));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int t;
    mem_model[4]  = 32'hDDCCBBAA;
    mem_model[8]  = 32'h44332211;
    mem_model[12] = 32'h88776655;
    //          wr addr     wd    chk rdata hit wb addr    data           fill addr
    vecs[0]  = mk(0, 16'h10, 0,     1, 8'hAA, 0, 0, 0,      0,             1, 14'h004);
    vecs[1]  = mk(0, 16'h11, 0,     1, 8'hBB, 1, 0, 0,      0,             0, 0);
    vecs[2]  = mk(1, 16'h12, 8'h55, 0, 0,     1, 0, 0,      0,             0, 0);
    vecs[3]  = mk(0, 16'h20, 0,     1, 8'h11, 0, 0, 0,      0,             1, 14'h008);
    vecs[4]  = mk(0, 16'h30, 0,     1, 8'h55, 0, 1, 14'h004, 32'hDD55BBAA, 1, 14'h00C);
    vecs[5]  = mk(0, 16'h12, 0,     1, 8'h55, 0, 0, 0,      0,             1, 14'h004);
    vecs[6]  = mk(0, 16'h21, 0,     1, 8'h22, 0, 0, 0,      0,             1, 14'h008);
    vecs[7]  = mk(0, 16'h13, 0,     1, 8'hDD, 1, 0, 0,      0,             0, 0);
    vecs[8]  = mk(0, 16'h30, 0,     1, 8'h55, 0, 0, 0,      0,             1, 14'h00C);
    vecs[9]  = mk(0, 16'h10, 0,     1, 8'hAA, 1, 0, 0,      0,             0, 0);
    vecs[10] = mk(1, 16'h05, 8'h77, 0, 0,     0, 0, 0,      0,             1, 14'h001);
    vecs[11] = mk(0, 16'h05, 0,     1, 8'h77, 1, 0, 0,      0,             0, 0);
    vecs[12] = mk(0, 16'h45, 0,     1, 8'h11, 0, 0, 0,      0,             1, 14'h011);
    vecs[13] = mk(0, 16'h85, 0,     1, 8'h21, 0, 1, 14'h001, 32'h01017701, 1, 14'h021);

    rst = 1'b1; core_req_valid = 1'b0; core_write = 1'b0; core_addr = '0; core_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_core_ready", 64'(core_ready), 64'd1);
    chk("rst_resp_valid", 64'(core_resp_valid), 64'd0);
    chk("rst_rdata", 64'(core_rdata), 64'd0);
    chk("rst_hit", 64'(core_hit), 64'd0);
    chk("rst_mem_req", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_hit_cnt", 64'(hit_count), 64'd0);
    chk("rst_miss_cnt", 64'(miss_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_req(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) chk("vec0_miss_cnt", 64'(miss_count), 64'd1);
      if (i == 1) chk("vec1_hit_cnt", 64'(hit_count), 64'd1);
    end
    chk("table_hit_cnt", 64'(hit_count), 64'd5);
    chk("table_miss_cnt", 64'(miss_count), 64'd9);

    // Stalled fill request, then reset while waiting for fill data.
    @(negedge clk);
    mem_stall = 1;
    core_req_valid = 1'b1; core_write = 1'b0; core_addr = 16'h0041;
    @(negedge clk);
    core_req_valid = 1'b0;
    t = 0;
    while (!mem_req_valid && t < 20) begin @(negedge clk); t++; end
    chk("stall_req_seen", 64'(mem_req_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_req", i), 64'(mem_req_valid), 64'd1);
      chk($sformatf("stall%0d_addr", i), 64'(mem_addr), 64'h010);
      chk($sformatf("stall%0d_write", i), 64'(mem_write), 64'd0);
      chk($sformatf("stall%0d_ready", i), 64'(core_ready), 64'd0);
    end
    mem_hold = 1;
    mem_stall = 0;
    t = 0;
    while (mem_req_valid && t < 20) begin @(negedge clk); t++; end
    chk("fill_wait_reached", 64'(mem_req_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pend = 0;
    mem_hold = 0;
    sb_q.delete();
    chk("abort_mem_req", 64'(mem_req_valid), 64'd0);
    chk("abort_core_ready", 64'(core_ready), 64'd1);
    @(negedge clk);
    chk("abort_idle_mem_req", 64'(mem_req_valid), 64'd0);
    run_req(mk(0, 16'h11, 0, 1, 8'hBB, 0, 0, 0, 0, 1, 14'h004), "post_rst");
    chk("post_rst_miss_cnt", 64'(miss_count), 64'd1);
    chk("post_rst_hit_cnt", 64'(hit_count), 64'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-002 The block SHALL have parameter BLOCK_BYTES, default 4, line size in bytes (power of 2, >=2).
REQ-003 The block SHALL have parameter NUM_SETS, default 4, number of sets (power of 2).
REQ-004 The block SHALL have parameter NUM_WAYS, default 2, associativity (1, 2 or 4).
REQ-005 The block SHALL have port clk, input, 1, clock; all state changes on rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 The block SHALL have port core_req_valid, input, 1, core request present.
REQ-008 The block SHALL have port core_ready, output, 1, cache idle and accepting requests.
REQ-009 The block SHALL have port core_write, input, 1, 1=byte write, 0=byte read.
REQ-010 The block SHALL have port core_addr, input, ADDR_W, byte address: offset=low log2(BLOCK_BYTES) bits, index=next log2(NUM_SETS) bits, tag=remainder.
REQ-011 The block SHALL have port core_wdata, input, 8, write byte.
REQ-012 The block SHALL have port core_resp_valid, output, 1, one-cycle response strobe.
REQ-013 The block SHALL have port core_rdata, output, 8, read byte, valid with core_resp_valid.
REQ-014 The block SHALL have port core_hit, output, 1, 1 if the request hit on first lookup, valid with core_resp_valid.
REQ-015 The block SHALL have port mem_req_valid, output, 1, memory request.
REQ-016 The block SHALL have port mem_ready, input, 1, memory accepts request this cycle.
REQ-017 The block SHALL have port mem_write, output, 1, 1=line write-back, 0=line fill.
REQ-018 The block SHALL have port mem_addr, output, ADDR_W-log2(BLOCK_BYTES), line address.
REQ-019 The block SHALL have port mem_wdata, output, BLOCK_BYTES*8, write-back line; byte k at bits [8k+7:8k].
REQ-020 The block SHALL have port mem_resp_valid, input, 1, write ack or fill data present.
REQ-021 The block SHALL have port mem_rdata, input, BLOCK_BYTES*8, fill line, same byte order.
REQ-022 The block SHALL have port hit_count, output, 32, saturating hit counter.
REQ-023 The block SHALL have port miss_count, output, 32, saturating miss counter.

Function
REQ-024 The FSM SHALL have states IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP; core_ready=1 only in IDLE.
REQ-025 In IDLE, core_req_valid=1 at a clock edge SHALL capture core_write/addr/wdata and enter LOOKUP; core inputs are ignored outside IDLE.
REQ-026 LOOKUP SHALL compare the tag against all valid ways of the indexed set in one cycle.
REQ-027 On a hit, LOOKUP SHALL perform the byte read or write, set dirty on write, update LRU, and enter RESP; core_resp_valid is high for exactly the RESP cycle, then IDLE. Hit latency is 2 cycles from acceptance edge to the response cycle.
REQ-028 On a first-lookup miss, LOOKUP SHALL increment miss_count and select a victim: the lowest-index invalid way, else the way with age NUM_WAYS-1. Dirty victim -> WB_REQ, else FILL_REQ.
REQ-029 A first-lookup hit SHALL increment hit_count. The re-lookup after a fill SHALL not change either counter. Both counters saturate at 32'hFFFFFFFF.
REQ-030 WB_REQ SHALL drive mem_req_valid=1, mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line, held stable until mem_ready=1 at an edge, then WB_WAIT.
REQ-031 WB_WAIT SHALL drop mem_req_valid and wait for mem_resp_valid; then clear victim dirty and enter FILL_REQ.
REQ-032 FILL_REQ SHALL drive mem_req_valid=1, mem_write=0, mem_addr={req tag, index} until mem_ready=1, then FILL_WAIT.
REQ-033 FILL_WAIT SHALL, on mem_resp_valid, write mem_rdata into the victim way (valid=1, dirty=0, new tag) and return to LOOKUP, which then hits. Writes allocate.
REQ-034 mem_resp_valid SHALL be ignored outside WB_WAIT/FILL_WAIT; memory never responds in the accept cycle.
REQ-035 LRU SHALL use per-way age counters of log2(NUM_WAYS) bits. On access, the accessed way gets age 0 and ways younger than its old age increment. NUM_WAYS=1 has no LRU state.
REQ-036 The FSM SHALL wait indefinitely on mem_ready/mem_resp_valid, with no timeout.

Reset
REQ-037 Reset SHALL force IDLE, clear all valid and dirty bits, set the age of way w to w, and zero both counters. Outputs go to: core_ready=1, core_resp_valid=0, core_rdata=0, core_hit=0, mem_req_valid=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-038 Reset in any state SHALL take effect on the next edge. The in-flight request and dirty data are discarded, and no further memory handshake is issued.

Verification (defaults; offset 2b, index 2b, tag 12b)
REQ-039 Reset, read 0x0010; mem returns 0xDDCCBBAA -> fill mem_addr=0x004, core_rdata=0xAA, core_hit=0, miss_count=1.
REQ-040 Then read 0x0011 -> no mem_req_valid, core_rdata=0xBB, core_hit=1, response 2 cycles after acceptance, hit_count=1.
REQ-041 Write 0x55 to 0x0012, read 0x0020 (fills way1), read 0x0030 -> write-back mem_addr=0x004 with mem_wdata=0xDD55BBAA, then fill mem_addr=0x00C.
REQ-042 Fill 0x0010 and 0x0020, re-read 0x0010, read 0x0030 -> victim is the way holding tag 0x002 (clean), no write-back, then 0x0010 still hits.
REQ-043 Hold mem_ready=0 for 5 cycles in FILL_REQ -> mem_req_valid and mem_addr stable, core_ready=0 throughout. Reset in FILL_WAIT -> next cycle mem_req_valid=0, core_ready=1, then read 0x0011 misses.
